// File: rtl/reg_status_file_if.sv
// Bundle between the ROB/decoder side and reg_status_file.
// Carries rdy/clear, commit and rename writes, and two read ports.
interface reg_status_file_if #(
    parameter int ROB_ID_W = 3
);
    logic                rdy;
    logic                clear;
    logic                commit_en;
    logic [4:0]          commit_reg;
    logic [31:0]         commit_val;
    logic [ROB_ID_W-1:0] commit_rob_id;
    logic                dep_en;
    logic [4:0]          dep_reg;
    logic [ROB_ID_W-1:0] dep_rob_id;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [31:0]         val1;
    logic                busy1;
    logic [ROB_ID_W-1:0] dep1;
    logic [31:0]         val2;
    logic                busy2;
    logic [ROB_ID_W-1:0] dep2;

    modport master (
        output rdy, clear,
        output commit_en, commit_reg, commit_val, commit_rob_id,
        output dep_en, dep_reg, dep_rob_id,
        output rs1, rs2,
        input  val1, busy1, dep1,
        input  val2, busy2, dep2
    );

    modport slave (
        input  rdy, clear,
        input  commit_en, commit_reg, commit_val, commit_rob_id,
        input  dep_en, dep_reg, dep_rob_id,
        input  rs1, rs2,
        output val1, busy1, dep1,
        output val2, busy2, dep2
    );
endinterface

// File: rtl/reg_status_file.sv
// Architectural register file with per-register busy flag and ROB id.
// Ports: clk, rst (sync, active-high), bus (reg_status_file_if.slave).
module reg_status_file #(
    parameter int ROB_ID_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    reg_status_file_if.slave bus
);
    logic [31:0]         r_val  [32];
    logic                r_busy [32];
    logic [ROB_ID_W-1:0] r_dep  [32];

    logic                w_commit;
    logic                w_cmatch;
    logic                w_rename;

    assign w_commit = bus.rdy && bus.commit_en &&
                      (bus.commit_reg != 5'd0);
    assign w_cmatch = w_commit && r_busy[bus.commit_reg] &&
                      (r_dep[bus.commit_reg] == bus.commit_rob_id);
    assign w_rename = bus.rdy && bus.dep_en && !bus.clear &&
                      (bus.dep_reg != 5'd0);

    // Later non-blocking writes win: rename overrides the commit's
    // busy release when both target the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_val[i]  <= '0;
                r_busy[i] <= 1'b0;
                r_dep[i]  <= '0;
            end
        end else if (bus.rdy) begin
            if (bus.clear) begin
                for (int i = 0; i < 32; i++) begin
                    r_busy[i] <= 1'b0;
                    r_dep[i]  <= '0;
                end
            end else if (w_cmatch) begin
                r_busy[bus.commit_reg] <= 1'b0;
                r_dep[bus.commit_reg]  <= '0;
            end
            if (w_commit) begin
                r_val[bus.commit_reg] <= bus.commit_val;
            end
            if (w_rename) begin
                r_busy[bus.dep_reg] <= 1'b1;
                r_dep[bus.dep_reg]  <= bus.dep_rob_id;
            end
        end
    end

    logic                w_byp1;
    logic                w_byp2;
    logic [31:0]         w_val1;
    logic                w_busy1;
    logic [ROB_ID_W-1:0] w_dep1;
    logic [31:0]         w_val2;
    logic                w_busy2;
    logic [ROB_ID_W-1:0] w_dep2;

    // Bypass only when the commit actually resolves the pending rename;
    // a stale commit must not hide the younger writer.
    assign w_byp1 = w_cmatch && (bus.commit_reg == bus.rs1);
    assign w_byp2 = w_cmatch && (bus.commit_reg == bus.rs2);

    always_comb begin
        w_val1  = r_val[bus.rs1];
        w_busy1 = r_busy[bus.rs1];
        w_dep1  = r_dep[bus.rs1];
        if (bus.rs1 == 5'd0) begin
            w_val1  = '0;
            w_busy1 = 1'b0;
            w_dep1  = '0;
        end else if (w_byp1) begin
            w_val1  = bus.commit_val;
            w_busy1 = 1'b0;
            w_dep1  = '0;
        end
    end

    always_comb begin
        w_val2  = r_val[bus.rs2];
        w_busy2 = r_busy[bus.rs2];
        w_dep2  = r_dep[bus.rs2];
        if (bus.rs2 == 5'd0) begin
            w_val2  = '0;
            w_busy2 = 1'b0;
            w_dep2  = '0;
        end else if (w_byp2) begin
            w_val2  = bus.commit_val;
            w_busy2 = 1'b0;
            w_dep2  = '0;
        end
    end

    assign bus.val1  = w_val1;
    assign bus.busy1 = w_busy1;
    assign bus.dep1  = w_dep1;
    assign bus.val2  = w_val2;
    assign bus.busy2 = w_busy2;
    assign bus.dep2  = w_dep2;
endmodule

// File: tb/tb_reg_status_file.sv
// Directed self-checking bench for reg_status_file.
// Drives the interface after posedge, checks outputs mid-cycle.
module tb_reg_status_file;
    localparam int RW = 3;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    reg_status_file_if #(.ROB_ID_W(RW)) bus ();

    reg_status_file #(.ROB_ID_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.clear         = 1'b0;
        bus.commit_en     = 1'b0;
        bus.commit_reg    = '0;
        bus.commit_val    = '0;
        bus.commit_rob_id = '0;
        bus.dep_en        = 1'b0;
        bus.dep_reg       = '0;
        bus.dep_rob_id    = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic rename(input logic [4:0] r, input logic [RW-1:0] id);
        bus.dep_en     = 1'b1;
        bus.dep_reg    = r;
        bus.dep_rob_id = id;
    endtask

    task automatic commit(input logic [4:0] r, input logic [RW-1:0] id,
                          input logic [31:0] v);
        bus.commit_en     = 1'b1;
        bus.commit_reg    = r;
        bus.commit_rob_id = id;
        bus.commit_val    = v;
    endtask

    task automatic q(input logic [4:0] a, input logic [4:0] b);
        bus.rs1 = a;
        bus.rs2 = b;
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        bus.rdy = 1'b1;
        bus.rs1 = '0;
        bus.rs2 = '0;
        idle();
        @(posedge clk);
        #1;

        // value write before reset
        commit(5, 1, 32'd7);
        step();
        q(5, 0);
        chk("pre_rst_val", bus.val1, 32'd7);

        // reset with rdy low
        bus.rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.rdy = 1'b1;
        q(5, 3);
        chk("rst_val5", bus.val1, 0);
        chk("rst_busy5", bus.busy1, 0);
        chk("rst_dep5", bus.dep1, 0);
        chk("rst_busy3", bus.busy2, 0);

        // rename then matching commit
        rename(3, 2);
        q(3, 3);
        chk("ren_same_cyc_busy", bus.busy1, 0);
        step();
        chk("ren_busy3", bus.busy1, 1);
        chk("ren_dep3", bus.dep1, 2);
        chk("ren_busy3_p2", bus.busy2, 1);
        commit(3, 2, 32'hDEAD);
        #1;
        chk("byp_val", bus.val1, 32'hDEAD);
        chk("byp_busy", bus.busy1, 0);
        chk("byp_dep", bus.dep1, 0);
        chk("byp_val_p2", bus.val2, 32'hDEAD);
        step();
        chk("cmt_val3", bus.val1, 32'hDEAD);
        chk("cmt_busy3", bus.busy1, 0);

        // stale commit
        rename(4, 1);
        step();
        rename(4, 5);
        step();
        commit(4, 1, 32'd9);
        q(4, 0);
        chk("stale_nobyp_val", bus.val1, 0);
        chk("stale_nobyp_busy", bus.busy1, 1);
        step();
        chk("stale_val", bus.val1, 32'd9);
        chk("stale_busy", bus.busy1, 1);
        chk("stale_dep", bus.dep1, 5);
        commit(4, 5, 32'd11);
        #1;
        chk("young_byp", bus.val1, 32'd11);
        step();
        chk("young_val", bus.val1, 32'd11);
        chk("young_busy", bus.busy1, 0);

        // commit + rename same register
        rename(6, 3);
        step();
        commit(6, 3, 32'h1234);
        rename(6, 4);
        q(6, 0);
        chk("sim_byp_val", bus.val1, 32'h1234);
        chk("sim_byp_busy", bus.busy1, 0);
        step();
        chk("sim_val", bus.val1, 32'h1234);
        chk("sim_busy", bus.busy1, 1);
        chk("sim_dep", bus.dep1, 4);

        // flush
        rename(1, 6);
        step();
        rename(2, 7);
        step();
        rename(31, 1);
        step();
        q(31, 2);
        chk("pre_clr_dep31", bus.dep1, 1);
        chk("pre_clr_dep2", bus.dep2, 7);
        bus.clear = 1'b1;
        rename(7, 3);
        commit(1, 6, 32'd5);
        step();
        q(1, 2);
        chk("clr_val1", bus.val1, 32'd5);
        chk("clr_busy1", bus.busy1, 0);
        chk("clr_busy2", bus.busy2, 0);
        chk("clr_dep2", bus.dep2, 0);
        q(31, 7);
        chk("clr_busy31", bus.busy1, 0);
        chk("clr_busy7", bus.busy2, 0);
        q(6, 4);
        chk("clr_busy6", bus.busy1, 0);
        chk("clr_dep4", bus.dep2, 0);

        // x0 writes ignored
        commit(0, 0, 32'd1);
        rename(0, 2);
        q(0, 0);
        chk("x0_same_cyc", bus.val1, 0);
        step();
        chk("x0_val", bus.val1, 0);
        chk("x0_busy", bus.busy2, 0);
        chk("x0_dep", bus.dep1, 0);

        // rdy low freezes state
        bus.rdy = 1'b0;
        rename(8, 2);
        step();
        q(8, 0);
        chk("rdy0_ren", bus.busy1, 0);
        bus.rdy = 1'b1;
        rename(9, 4);
        step();
        bus.rdy = 1'b0;
        commit(9, 4, 32'd77);
        q(9, 0);
        chk("rdy0_nobyp_busy", bus.busy1, 1);
        chk("rdy0_nobyp_val", bus.val1, 0);
        step();
        bus.clear = 1'b1;
        commit(10, 0, 32'd3);
        step();
        q(9, 10);
        chk("rdy0_busy9", bus.busy1, 1);
        chk("rdy0_dep9", bus.dep1, 4);
        chk("rdy0_val9", bus.val1, 0);
        chk("rdy0_val10", bus.val2, 0);
        bus.rdy = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
